// File: rtl/instruction_cb_encoder_pkg.sv
// Shared constants and types for the RV32C CB-format encoder.
package instruction_cb_encoder_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned HALF_W  = 16;
  localparam int unsigned CNT_W   = 16;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;
  localparam logic [2:0] F3_ANDI = 3'b111;

  localparam logic [6:0] F7_SRLI = 7'b0000000;
  localparam logic [6:0] F7_SRAI = 7'b0100000;

  localparam logic [1:0] C_Q1 = 2'b01;

  localparam logic [2:0] CB_F3_BEQZ = 3'b110;
  localparam logic [2:0] CB_F3_BNEZ = 3'b111;
  localparam logic [2:0] CB_F3_ALU  = 3'b100;

  localparam logic [1:0] CB_F2_SRLI = 2'b00;
  localparam logic [1:0] CB_F2_SRAI = 2'b01;
  localparam logic [1:0] CB_F2_ANDI = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EMIT_LO = 2'd1,
    EMIT_HI = 2'd2
  } state_t;

  // Field view of a base-ISA instruction word.
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rv32_fields_t;

  // True for x8..x15, the registers reachable by a 3-bit compressed field.
  function automatic logic is_creg(input logic [4:0] r);
    return r[4:3] == 2'b01;
  endfunction

endpackage

// File: rtl/instruction_cb_encoder_cb_compress_logic.sv
// Combinational CB-format classifier/encoder for a single RV32I instruction.
module cb_compress_logic
  import instruction_cb_encoder_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic               can_compress,
  output logic [HALF_W-1:0]  half
);

  rv32_fields_t f;
  logic [12:0]  boff;
  logic [11:0]  imm;
  logic         br_ok;
  logic         sh_ok;
  logic         andi_ok;

  assign f    = rv32_fields_t'(instr);
  assign boff = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm  = instr[31:20];

  // Branch offset fits 9 signed bits when bits 12..8 are a pure sign extension.
  assign br_ok = (f.opcode == OPC_BRANCH)
              && (f.funct3 == F3_BEQ || f.funct3 == F3_BNE)
              && (f.rs2 == 5'd0) && is_creg(f.rs1)
              && (boff[12:8] == 5'b00000 || boff[12:8] == 5'b11111);

  assign sh_ok = (f.opcode == OPC_OP_IMM) && (f.funct3 == F3_SRXI)
              && (f.funct7 == F7_SRLI || f.funct7 == F7_SRAI)
              && (f.rd == f.rs1) && is_creg(f.rd) && (f.rs2 != 5'd0);

  assign andi_ok = (f.opcode == OPC_OP_IMM) && (f.funct3 == F3_ANDI)
                && (f.rd == f.rs1) && is_creg(f.rd)
                && (imm[11:5] == 7'h00 || imm[11:5] == 7'h7F);

  always_comb begin
    can_compress = br_ok | sh_ok | andi_ok;
    half         = '0;
    if (br_ok) begin
      half = {(f.funct3 == F3_BEQ) ? CB_F3_BEQZ : CB_F3_BNEZ, boff[8], boff[4:3],
              f.rs1[2:0], boff[7:6], boff[2:1], boff[5], C_Q1};
    end else if (sh_ok) begin
      half = {CB_F3_ALU, 1'b0, f.funct7[5] ? CB_F2_SRAI : CB_F2_SRLI,
              f.rd[2:0], f.rs2, C_Q1};
    end else if (andi_ok) begin
      half = {CB_F3_ALU, imm[5], CB_F2_ANDI, f.rd[2:0], imm[4:0], C_Q1};
    end
  end

endmodule

// File: rtl/instruction_cb_encoder.sv
// Streaming RV32I -> halfword encoder: CB-compressible instructions become one
// halfword, all others pass through as low then high halfword.
module instruction_cb_encoder
  import instruction_cb_encoder_pkg::*;
(
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iVALID,
  output logic               oREADY,
  input  logic [INSTR_W-1:0] iINSTR,
  output logic               oVALID,
  input  logic               iREADY,
  output logic [HALF_W-1:0]  oHALF,
  output logic               oCOMPRESSED,
  output logic               oLAST,
  output logic [CNT_W-1:0]   oCNT_COMP
);

  state_t              state;
  logic [HALF_W-1:0]   instr_hi;
  logic                can_compress;
  logic [HALF_W-1:0]   cb_half;
  logic                final_hs;
  logic                accept;

  cb_compress_logic u_cb (
    .instr        (iINSTR),
    .can_compress (can_compress),
    .half         (cb_half)
  );

  // Ready in IDLE, or on the cycle the last halfword is taken, so
  // instructions stream without a bubble.
  assign final_hs = oVALID & oLAST & iREADY;
  assign oREADY   = (state == IDLE) | final_hs;
  assign accept   = oREADY & iVALID;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state       <= IDLE;
      instr_hi    <= '0;
      oVALID      <= 1'b0;
      oHALF       <= '0;
      oCOMPRESSED <= 1'b0;
      oLAST       <= 1'b0;
    end else if (accept) begin
      state       <= EMIT_LO;
      instr_hi    <= iINSTR[INSTR_W-1:HALF_W];
      oVALID      <= 1'b1;
      oHALF       <= can_compress ? cb_half : iINSTR[HALF_W-1:0];
      oCOMPRESSED <= can_compress;
      oLAST       <= can_compress;
    end else begin
      case (state)
        IDLE: state <= IDLE;
        EMIT_LO: begin
          if (iREADY) begin
            if (oLAST) begin
              state       <= IDLE;
              oVALID      <= 1'b0;
              oCOMPRESSED <= 1'b0;
              oLAST       <= 1'b0;
            end else begin
              state       <= EMIT_HI;
              oHALF       <= instr_hi;
              oCOMPRESSED <= 1'b0;
              oLAST       <= 1'b1;
            end
          end
        end
        EMIT_HI: begin
          if (iREADY) begin
            state       <= IDLE;
            oVALID      <= 1'b0;
            oCOMPRESSED <= 1'b0;
            oLAST       <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          oVALID      <= 1'b0;
          oCOMPRESSED <= 1'b0;
          oLAST       <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of compressed halfwords taken downstream.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oCNT_COMP <= '0;
    end else if (oVALID && iREADY && oCOMPRESSED && (oCNT_COMP != '1)) begin
      oCNT_COMP <= oCNT_COMP + CNT_W'(1);
    end
  end

endmodule

// File: doc/instruction_cb_encoder.md
# instruction_cb_encoder

Streaming RV32C CB-format compressor: accepts 32-bit RV32I instructions over a valid/ready handshake and emits a 16-bit halfword stream. Instructions expressible as c.beqz, c.bnez, c.srli, c.srai or c.andi are emitted as one CB halfword. All others pass through as two halfwords, low half first. It sits between the program/instruction generator and the instruction memory writer, as the encode-side counterpart of the CB decode path.

## Interface
- No parameters.
- iCLK  in  1  clock; all state updates on posedge.
- iRST  in  1  reset, asynchronous, active-high.
- iVALID  in  1  input instruction valid.
- oREADY  out  1  encoder can accept iINSTR this cycle.
- iINSTR  in  32  RV32I instruction.
- oVALID  out  1  oHALF valid.
- iREADY  in  1  downstream accepts oHALF this cycle.
- oHALF  out  16  emitted halfword.
- oCOMPRESSED  out  1  oHALF is a CB encoding; valid with oVALID.
- oLAST  out  1  oHALF is the final halfword of the current instruction.
- oCNT_COMP  out  16  saturating count of compressed instructions emitted.

## Operation
- Classification (combinational on the latched instruction; rs1/rd must be x8..x15, encoded as reg-8 in [9:7]):
  - c.beqz / c.bnez: opcode 1100011, funct3 000/001, rs2=x0, offset in -256..254 → [15:13]=110/111, [12]=off[8], [11:10]=off[4:3], [6:5]=off[7:6], [4:3]=off[2:1], [2]=off[5], [1:0]=01.
  - c.srli / c.srai: opcode 0010011, funct3 101, funct7 0000000/0100000, rd=rs1, shamt 1..31 → [15:13]=100, [12]=0, [11:10]=00/01, [6:2]=shamt, [1:0]=01.
  - c.andi: opcode 0010011, funct3 111, rd=rs1, sign-extended imm in -32..31 → [15:13]=100, [12]=imm[5], [11:10]=10, [6:2]=imm[4:0], [1:0]=01.
  - Everything else, including shamt=0, a register outside x8..x15, an out-of-range immediate, and iINSTR[1:0]≠11, is non-compressible.
- FSM with states IDLE, EMIT_LO and EMIT_HI:
  - IDLE: oREADY=1 and oVALID=0. On iVALID, latch iINSTR and go to EMIT_LO.
  - EMIT_LO: oVALID=1. oHALF is the CB encoding (oCOMPRESSED=1, oLAST=1) or iINSTR[15:0] (oCOMPRESSED=0, oLAST=0).
    - On iREADY with a compressed instruction: final halfword (see below).
    - On iREADY otherwise: go to EMIT_HI.
  - EMIT_HI: oHALF=instr[31:16], oCOMPRESSED=0, oLAST=1. On iREADY: final halfword.
  - Final-halfword handshake (oVALID&oLAST&iREADY): oREADY=1 combinationally. If iVALID is also high, latch the new instruction and go to EMIT_LO; otherwise go to IDLE.
- Any other state: oREADY=0.
- oCNT_COMP increments on each accepted compressed halfword and saturates at 0xFFFF.

## Timing
- Reset (asynchronous): state=IDLE, oVALID=0, oHALF=0, oCOMPRESSED=0, oLAST=0, oCNT_COMP=0, oREADY=1 after reset deasserts. The latched instruction is discarded.
- Latency: accept at edge N gives oVALID at N+1.
- Throughput: one halfword per cycle under continuous iREADY, with no bubble between instructions.
- Backpressure: while oVALID&!iREADY, oHALF, oCOMPRESSED, oLAST and internal state hold stable.
- Reset asserted mid-EMIT_HI drops the pending high half; no partial instruction is emitted after reset.
- The counter holds at 0xFFFF on further compressed emits.

## Structure
- Shared package/header: opcodes (BRANCH=1100011, OP_IMM=0010011), funct3/funct7 constants, C quadrant 01, CB funct3 values (110/111/100), CB funct2 values (00/01/10), and FSM state encodings.
- One combinational sub-module, cb_compress_logic: input instr[31:0], outputs can_compress and half[15:0]. The top level holds the FSM, latch and counter.

## Test plan
- beq x8,x0,+8 (0x00040463), iREADY=1 → single halfword 0xC401, oCOMPRESSED=1, oLAST=1, oCNT_COMP=1.
- srli x9,x9,3 (0x0034D493) then andi x10,x10,-1 (0xFFF57513) back-to-back → 0x808D, 0x997D on consecutive cycles, oREADY high throughout.
- andi x10,x10,32 (0x02057513) → 0x7513 (oLAST=0) then 0x0205 (oLAST=1), oCOMPRESSED=0, counter unchanged.
- srli x8,x8,0 and beq x9,x1,+8 → each emitted as two raw halfwords, oCOMPRESSED=0.
- Backpressure: hold iREADY=0 for 3 cycles in EMIT_LO of a raw instruction → oHALF is stable and oREADY=0; release → low half then high half, each once.
- Assert iRST during EMIT_HI → outputs at reset values immediately; after release, the next input emits normally with no stale high half.
